dm_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the data memory (`dm`). It shares the single `dm` access port between the CPU load/store stage (port 0) and an auxiliary master such as a loader/DMA (port 1). It grants at most one access per cycle and screens misaligned or illegal accesses. Read data is returned with a registered valid strobe. It drives `dm`'s `PC/MemWrite/WBH/A/Din` and consumes its combinational `Dout`.

---
 rtl/dm_arbiter.sv | 155 +++++++++++++++
 tb/tb_dm_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port data-memory arbiter with legality screening and registered responses
// Optional feature: DM_ARB_FIXED_PRIO_EN (port 0 always wins contention, port 1 starvation notice)
module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  wbh0,
  input  logic [1:0]  wbh1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [31:0] pc0,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] m_pc,
  output logic        m_we,
  output logic [1:0]  m_wbh,
  output logic [31:0] m_a,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout
);

  logic        last_q, last_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [15:0] stall_cnt0_q, stall_cnt0_d, stall_cnt1_q, stall_cnt1_d;

  logic        win_valid, win1, illegal, legal;
  logic        sel_we;
  logic [1:0]  sel_wbh;
  logic [31:0] sel_addr, sel_wdata, sel_pc, load_data;

  // Pick the winner, screen its access and steer it onto the dm port
  always_comb begin
    win_valid = req0 | req1;
`ifdef DM_ARB_FIXED_PRIO_EN
    win1 = req1 & ~req0;
`else
    // Under contention the port that was not served most recently wins
    win1 = req1 & (~req0 | ~last_q);
`endif
    gnt0 = req0 & ~win1;
    gnt1 = win1;

    sel_we    = win1 ? we1    : we0;
    sel_wbh   = win1 ? wbh1   : wbh0;
    sel_addr  = win1 ? addr1  : addr0;
    sel_wdata = win1 ? wdata1 : wdata0;
    sel_pc    = win1 ? 32'h0000_0000 : pc0;

    illegal = (sel_wbh == 2'b11)
            | ((sel_wbh == 2'b00) & (sel_addr[1:0] != 2'b00))
            | ((sel_wbh == 2'b10) & sel_addr[0])
            | (sel_addr >= ADDR_LIMIT);
    legal   = win_valid & ~illegal;

    // Illegal or absent accesses present an idle bus so dm never sees a bad address
    m_we  = legal & sel_we & ~Reset;
    m_wbh = legal ? sel_wbh   : 2'b00;
    m_a   = legal ? sel_addr  : 32'h0;
    m_din = legal ? sel_wdata : 32'h0;
    m_pc  = legal ? sel_pc    : 32'h0;

    load_data = (legal & ~sel_we) ? m_dout : 32'h0;
  end

  // Next-state for round-robin pointer, response registers and stall counters
  always_comb begin
    last_d    = win_valid ? win1 : last_q;
    rvalid0_d = gnt0;
    rvalid1_d = gnt1;
    err0_d    = gnt0 & illegal;
    err1_d    = gnt1 & illegal;
    rdata0_d  = gnt0 ? load_data : rdata0_q;
    rdata1_d  = gnt1 ? load_data : rdata1_q;

    stall_cnt0_d = stall_cnt0_q;
    if (gnt0)
      stall_cnt0_d = 16'h0;
    else if (req0 && stall_cnt0_q != 16'hFFFF)
      stall_cnt0_d = stall_cnt0_q + 16'h1;

    stall_cnt1_d = stall_cnt1_q;
    if (gnt1)
      stall_cnt1_d = 16'h0;
    else if (req1 && stall_cnt1_q != 16'hFFFF)
      stall_cnt1_d = stall_cnt1_q + 16'h1;
  end

  // State registers; reset wins over any grant in the same cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q       <= 1'b1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
      stall_cnt0_q <= 16'h0;
      stall_cnt1_q <= 16'h0;
    end else begin
      last_q       <= last_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      stall_cnt0_q <= stall_cnt0_d;
      stall_cnt1_q <= stall_cnt1_d;
    end
  end

`ifdef DM_ARB_FIXED_PRIO_EN
  logic starved_q, starved_d;

  // Report port 1 starvation once per reset when its stall counter saturates
  always_comb begin
    starved_d = starved_q | (stall_cnt1_q == 16'hFFFF);
  end

  // Starvation notice register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      starved_q <= 1'b0;
    end else begin
      if (!starved_q && stall_cnt1_q == 16'hFFFF)
        $display("dm_arbiter: port1 starved");
      starved_q <= starved_d;
    end
  end
`endif

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized self-checking bench for dm_arbiter with dm and reference models
module tb_dm_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req0, req1, we0, we1;
  logic [1:0]  wbh0, wbh1;
  logic [31:0] addr0, addr1, wdata0, wdata1, pc0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] m_pc, m_a, m_din, m_dout;
  logic        m_we;
  logic [1:0]  m_wbh;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  dm_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wbh0(wbh0), .wbh1(wbh1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .pc0(pc0),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .m_pc(m_pc), .m_we(m_we), .m_wbh(m_wbh), .m_a(m_a), .m_din(m_din),
    .m_dout(m_dout)
  );

  // dm stand-in: little-endian byte memory, combinational read, write at posedge
  logic [7:0]  mem  [0:16383];
  logic [7:0]  smem [0:16383];
  logic [13:0] ia;
  assign ia = m_a[13:0];
  assign m_dout = (m_wbh == 2'b00) ? {mem[ia+14'd3], mem[ia+14'd2], mem[ia+14'd1], mem[ia]} :
                  (m_wbh == 2'b01) ? {24'h0, mem[ia]} :
                  (m_wbh == 2'b10) ? {16'h0, mem[ia+14'd1], mem[ia]} : 32'h0;

  always @(posedge Clk) begin
    if (m_we) begin
      mem[ia] <= m_din[7:0];
      if (m_wbh != 2'b01) mem[ia+14'd1] <= m_din[15:8];
      if (m_wbh == 2'b00) begin
        mem[ia+14'd2] <= m_din[23:16];
        mem[ia+14'd3] <= m_din[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [1:0] sz);
    logic [13:0] i;
    i = a[13:0];
    case (sz)
      2'b00:   return {smem[i+14'd3], smem[i+14'd2], smem[i+14'd1], smem[i]};
      2'b01:   return {24'h0, smem[i]};
      2'b10:   return {16'h0, smem[i+14'd1], smem[i]};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model state
  int          last_m = 1;
  bit          exp_rv [2];
  bit          exp_err[2];
  logic [31:0] exp_rd [2];
  bit          gd     [2];
  bit          reg_known = 0;
  int          obs_win;

  // One clock: check outputs at negedge against the model, then advance the model
  task automatic tick();
    int w;
    bit ill, we;
    logic [31:0] a, d, pc;
    logic [1:0] sz;
    @(negedge Clk);
    gd[0] = 0; gd[1] = 0;
    obs_win = gnt1 ? 1 : (gnt0 ? 0 : -1);
    if (reg_known) begin
      chk("rvalid0", rvalid0, exp_rv[0]);
      chk("rvalid1", rvalid1, exp_rv[1]);
      if (exp_rv[0]) chk("err0", err0, exp_err[0]);
      if (exp_rv[1]) chk("err1", err1, exp_err[1]);
      if (exp_rv[0] && !exp_err[0]) chk("rdata0", rdata0, exp_rd[0]);
      if (exp_rv[1] && !exp_err[1]) chk("rdata1", rdata1, exp_rd[1]);
    end
    exp_rv[0] = 0; exp_rv[1] = 0;
    if (Reset) begin
      chk("m_we_in_reset", m_we, 0);
      exp_err[0] = 0; exp_err[1] = 0;
      exp_rd[0] = 0; exp_rd[1] = 0;
      last_m = 1;
      reg_known = 1;
    end else begin
      w = -1;
      if (req0 && req1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (last_m == 0) ? 1 : 0;
`endif
      end else if (req0) w = 0;
      else if (req1) w = 1;
      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      if (w >= 0) begin
        a  = (w == 0) ? addr0 : addr1;
        sz = (w == 0) ? wbh0 : wbh1;
        d  = (w == 0) ? wdata0 : wdata1;
        we = (w == 0) ? we0 : we1;
        pc = (w == 0) ? pc0 : 32'h0;
        ill = (sz == 2'd3) || (sz == 2'd0 && a % 4 != 0) ||
              (sz == 2'd2 && a % 2 != 0) || (a >= 32'h3000);
        chk("m_we", m_we, !ill && we);
        if (!ill) begin
          chk("m_a", m_a, a);
          chk("m_wbh", m_wbh, sz);
          chk("m_din", m_din, d);
          chk("m_pc", m_pc, pc);
        end
        exp_rv[w]  = 1;
        exp_err[w] = ill;
        exp_rd[w]  = (!ill && !we) ? ref_rd(a, sz) : 32'h0;
        if (!ill && we) begin
          smem[a[13:0]] = d[7:0];
          if (sz != 2'd1) smem[a[13:0]+14'd1] = d[15:8];
          if (sz == 2'd0) begin
            smem[a[13:0]+14'd2] = d[23:16];
            smem[a[13:0]+14'd3] = d[31:24];
          end
        end
        last_m = w;
        gd[w] = 1;
      end else begin
        chk("idle_m_we", m_we, 0);
        chk("idle_m_a", m_a, 0);
        chk("idle_m_wbh", m_wbh, 0);
        chk("idle_m_din", m_din, 0);
        chk("idle_m_pc", m_pc, 0);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; wbh0 = sz; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; wbh1 = sz; addr1 = a; wdata1 = d; end
  endtask

  // Issue one request, hold it until granted, then drop it
  task automatic do_req(input int p, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    bit done;
    done = 0;
    set_port(p, 1'b1, w, sz, a, d);
    for (int k = 0; k < 4 && !done; k++) begin
      tick();
      done = gd[p];
    end
    if (!done) chk("grant_timeout", 0, 1);
    set_port(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 63));
      2:       return 32'h2FF0 + 32'($urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) begin mem[i] = 8'h0; smem[i] = 8'h0; end
    Reset = 1'b1;
    pc0 = 32'h0000_0400;
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_err0", err0, 0);
    chk("rst_err1", err1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    Reset = 1'b0;

    do_req(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
    chk("st_rvalid0", rvalid0, 1);
    chk("st_err0", err0, 0);
    do_req(0, 1'b0, 2'b00, 32'h10, 32'h0);
    chk("ld_deadbeef", rdata0, 32'hDEADBEEF);

    do_req(0, 1'b1, 2'b00, 32'h10, 32'h11223344);
    do_req(1, 1'b0, 2'b10, 32'h12, 32'h0);
    chk("half_ld", rdata1, 32'h0000_1122);

    do_req(0, 1'b1, 2'b00, 32'h13, 32'hFFFFFFFF);
    chk("mis_err0", err0, 1);
    do_req(0, 1'b1, 2'b11, 32'h10, 32'hFFFFFFFF);
    chk("wbh11_err0", err0, 1);
    do_req(0, 1'b1, 2'b00, 32'h3000, 32'hFFFFFFFF);
    chk("limit_err0", err0, 1);
    do_req(0, 1'b0, 2'b00, 32'h10, 32'h0);
    chk("mem_unchanged", rdata0, 32'h11223344);

    set_port(0, 1'b1, 1'b1, 2'b00, 32'h20, 32'hCAFEF00D);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("rst_store_rvalid0", rvalid0, 0);
    tick();
    do_req(0, 1'b0, 2'b00, 32'h20, 32'h0);
    chk("rst_store_nowrite", rdata0, 32'h0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;

    set_port(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 2'b00, 32'h14, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef DM_ARB_FIXED_PRIO_EN
      chk("contend_win", obs_win, 0);
`else
      chk("contend_win", obs_win, k % 2);
`endif
    end
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      if (!req0 && $urandom_range(0, 9) < 6)
        set_port(0, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(), $urandom);
      if (!req1 && $urandom_range(0, 9) < 6)
        set_port(1, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(), $urandom);
      pc0 = $urandom;
      tick();
      if (gd[0]) req0 = 1'b0;
      if (gd[1]) req1 = 1'b0;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
